// File: rtl/serializador.sv
// -----------------------------------------------------------------------------
// serializador - transmit side of the byte-serial link
//
// Accepts WIDTH-bit words from a producer through a valid/ready handshake,
// buffers them in a DEPTH-entry FIFO and shifts each word out one bit per
// clock, LSB first. Shifting only advances on cycles where the receiver
// reports it can take a bit (status_in = 1). Otherwise the current bit is
// held back and the word is paused.
//
// Ports
//   clock_100KHz  in   1      system clock, all state on the rising edge
//   reset         in   1      asynchronous, active-low
//   data_in       in   WIDTH  word from the producer
//   data_valid    in   1      producer offers data_in this cycle
//   ready_in      out  1      FIFO has room (combinational); a transfer is
//                             data_valid && ready_in
//   data_out      out  1      serial bit toward the deserializer
//   write_out     out  1      data_out carries a valid bit this cycle
//   status_in     in   1      receiver can accept a bit
//   word_sent     out  1      one-cycle pulse after the last bit of a word
//   busy          out  1      FIFO non-empty or a word is in flight
// -----------------------------------------------------------------------------
module serializador #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             ready_in,
    output logic             data_out,
    output logic             write_out,
    input  logic             status_in,
    output logic             word_sent,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // FIFO storage: plain array, no reset, so it maps onto memory primitives.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_data_out;
    logic             r_write_out;
    logic             r_word_sent;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic [OCC_W-1:0] w_count_next;
    logic             w_cur_bit;
    logic             w_last_bit;

    assign ready_in  = (r_count != OCC_W'(DEPTH));
    assign w_push    = data_valid && ready_in;
    // The only consumer of the FIFO is the IDLE->SHIFT transition.
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);

    assign w_count_next = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

    // bit_cnt stays below WIDTH while in SHIFT, so its low bits index the word.
    assign w_cur_bit  = r_shreg[r_bit_cnt[CNT_W-2:0]];
    assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));

    assign data_out  = r_data_out;
    assign write_out = r_write_out;
    assign word_sent = r_word_sent;
    assign busy      = r_busy;

    // FIFO write port
    always_ff @(posedge clock_100KHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Shift FSM with registered outputs. busy is loaded with the value that
    // matches the state/occupancy being entered, so it is never a cycle stale.
    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_data_out  <= 1'b0;
            r_write_out <= 1'b0;
            r_word_sent <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_word_sent <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_write_out <= 1'b0;
                    if (w_pop) begin
                        r_shreg   <= r_mem[r_rd_ptr];
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                    r_busy <= w_pop || (w_count_next != '0);
                end
                ST_SHIFT: begin
                    if (status_in) begin
                        r_data_out  <= w_cur_bit;
                        r_write_out <= 1'b1;
                        r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                        if (w_last_bit) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        // Receiver stalled: bit is not consumed, data_out held.
                        r_write_out <= 1'b0;
                    end
                    r_busy <= 1'b1;
                end
                ST_DONE: begin
                    // Forced gap between words lets the receiver drop status_in.
                    r_write_out <= 1'b0;
                    r_word_sent <= 1'b1;
                    r_state     <= ST_IDLE;
                    r_busy      <= (w_count_next != '0);
                end
                default: begin
                    r_write_out <= 1'b0;
                    r_state     <= ST_IDLE;
                    r_busy      <= (w_count_next != '0);
                end
            endcase
        end
    end

endmodule
